// File: rtl/box_arbiter.sv
// Two-requester round-robin arbiter in front of a single register box.
// One transaction in flight: accept, issue a box strobe, optionally wait for read data, respond.
module box_arbiter #(
  parameter int TIMEOUT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic       req0_write,
  input  logic [1:0] req0_addr,
  input  logic [7:0] req0_wdata,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic       req1_write,
  input  logic [1:0] req1_addr,
  input  logic [7:0] req1_wdata,
  output logic       req1_ready,
  output logic       rsp0_valid,
  output logic [7:0] rsp0_data,
  output logic       rsp0_err,
  output logic       rsp1_valid,
  output logic [7:0] rsp1_data,
  output logic       rsp1_err,
  output logic       box_read_enable,
  output logic       box_write_enable,
  output logic [1:0] box_address,
  output logic [7:0] box_write_data,
  input  logic [7:0] box_read_data,
  input  logic       box_read_active
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  // WAIT ends on the TIMEOUT-th cycle without read data; the 3-bit counter covers TIMEOUT <= 7.
  localparam logic [2:0] WAIT_LAST = 3'(TIMEOUT - 1);

  state_t     state, state_next;
  logic       rr;
  logic       cap_id;
  logic       cap_write;
  logic [1:0] cap_addr;
  logic [7:0] cap_wdata;
  logic [7:0] rsp_data_q;
  logic       rsp_err_q;
  logic [2:0] wait_cnt;
  logic [1:0] req_valid;
  logic       winner;
  logic       grant;
  logic       wait_done;

  assign req_valid = {req1_valid, req0_valid};
  assign wait_done = (wait_cnt >= WAIT_LAST);

  always_comb begin
    state_next = state;
    winner     = req_valid[rr] ? rr : ~rr;
    grant      = 1'b0;
    case (state)
      IDLE: begin
        grant = !rst && (|req_valid);
        if (grant) state_next = ISSUE;
      end
      ISSUE:   state_next = cap_write ? RESP : WAIT;
      WAIT:    if (box_read_active || wait_done) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign req0_ready       = grant && !winner;
  assign req1_ready       = grant && winner;
  assign box_write_enable = (state == ISSUE) && cap_write;
  assign box_read_enable  = (state == ISSUE) && !cap_write;
  assign box_address      = cap_addr;
  assign box_write_data   = cap_wdata;

  // Responses are steered to the captured requester only; the other side stays quiet.
  assign rsp0_valid = (state == RESP) && !cap_id;
  assign rsp1_valid = (state == RESP) && cap_id;
  assign rsp0_data  = rsp0_valid ? rsp_data_q : 8'h00;
  assign rsp1_data  = rsp1_valid ? rsp_data_q : 8'h00;
  assign rsp0_err   = rsp0_valid && rsp_err_q;
  assign rsp1_err   = rsp1_valid && rsp_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rr         <= 1'b0;
      cap_id     <= 1'b0;
      cap_write  <= 1'b0;
      cap_addr   <= 2'b00;
      cap_wdata  <= 8'h00;
      rsp_data_q <= 8'h00;
      rsp_err_q  <= 1'b0;
      wait_cnt   <= 3'd0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (grant) begin
            cap_id     <= winner;
            cap_write  <= winner ? req1_write : req0_write;
            cap_addr   <= winner ? req1_addr  : req0_addr;
            cap_wdata  <= winner ? req1_wdata : req0_wdata;
            rr         <= ~winner;
            rsp_data_q <= 8'h00;
            rsp_err_q  <= 1'b0;
          end
        end
        ISSUE: begin
          wait_cnt <= 3'd0;
          if (cap_write) begin
            rsp_data_q <= cap_wdata;
            rsp_err_q  <= 1'b0;
          end
        end
        WAIT: begin
          if (box_read_active) begin
            rsp_data_q <= box_read_data;
            rsp_err_q  <= 1'b0;
          end else if (wait_done) begin
            rsp_data_q <= 8'h00;
            rsp_err_q  <= 1'b1;
          end else if (wait_cnt != 3'd7) begin
            wait_cnt <= wait_cnt + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_box_arbiter.sv
// Directed bench for box_arbiter: a cycle-by-cycle vector table plus hand sequences
// for arbitration fairness, back-to-back spacing, read timeout and reset mid-read.
module tb_box_arbiter;

  localparam int TIMEOUT = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req0_write, req1_valid, req1_write;
  logic [1:0] req0_addr, req1_addr;
  logic [7:0] req0_wdata, req1_wdata;
  logic       req0_ready, req1_ready;
  logic       rsp0_valid, rsp0_err, rsp1_valid, rsp1_err;
  logic [7:0] rsp0_data, rsp1_data;
  logic       box_read_enable, box_write_enable;
  logic [1:0] box_address;
  logic [7:0] box_write_data;
  logic [7:0] box_read_data;
  logic       box_read_active;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  box_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_ready(req1_ready),
    .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data), .rsp0_err(rsp0_err),
    .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data), .rsp1_err(rsp1_err),
    .box_read_enable(box_read_enable), .box_write_enable(box_write_enable),
    .box_address(box_address), .box_write_data(box_write_data),
    .box_read_data(box_read_data), .box_read_active(box_read_active)
  );

  typedef struct {
    logic       rst;
    logic       v0, w0; logic [1:0] a0; logic [7:0] d0;
    logic       v1, w1; logic [1:0] a1; logic [7:0] d1;
    logic [7:0] brd;    logic       bra;
    logic       r0, r1, re, we; logic [1:0] ba; logic [7:0] bwd;
    logic       s0, s1; logic [7:0] sd;  logic       se;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idleInputs();
    req0_valid = 0; req0_write = 0; req0_addr = 0; req0_wdata = 0;
    req1_valid = 0; req1_write = 0; req1_addr = 0; req1_wdata = 0;
    box_read_data = 0; box_read_active = 0;
  endtask

  // Leaves the caller at a falling edge in the first cycle after reset.
  task automatic doReset();
    @(negedge clk);
    idleInputs();
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
  endtask

  task automatic applyStimulus(input vec_t v);
    rst = v.rst;
    req0_valid = v.v0; req0_write = v.w0; req0_addr = v.a0; req0_wdata = v.d0;
    req1_valid = v.v1; req1_write = v.w1; req1_addr = v.a1; req1_wdata = v.d1;
    box_read_data = v.brd; box_read_active = v.bra;
  endtask

  task automatic checkOutput(input vec_t v, input int i);
    check($sformatf("row%0d req0_ready", i), req0_ready, v.r0);
    check($sformatf("row%0d req1_ready", i), req1_ready, v.r1);
    check($sformatf("row%0d box_re", i), box_read_enable, v.re);
    check($sformatf("row%0d box_we", i), box_write_enable, v.we);
    check($sformatf("row%0d box_addr", i), box_address, v.ba);
    check($sformatf("row%0d box_wdata", i), box_write_data, v.bwd);
    check($sformatf("row%0d rsp0_valid", i), rsp0_valid, v.s0);
    check($sformatf("row%0d rsp0_data", i), rsp0_data, v.s0 ? v.sd : 8'h00);
    check($sformatf("row%0d rsp0_err", i), rsp0_err, v.s0 ? v.se : 1'b0);
    check($sformatf("row%0d rsp1_valid", i), rsp1_valid, v.s1);
    check($sformatf("row%0d rsp1_data", i), rsp1_data, v.s1 ? v.sd : 8'h00);
    check($sformatf("row%0d rsp1_err", i), rsp1_err, v.s1 ? v.se : 1'b0);
  endtask

  initial begin
    int cyc, grants, rsps, n, found;
    logic exp_grant, last_grant;
    int times[3];

    //           rst v0 w0 a0 d0     v1 w1 a1 d1     brd    bra  r0 r1 re we ba bwd    s0 s1 sd     se
    vecs[0]  = '{1, 1, 1, 0, 8'hAA, 0, 0, 0, 8'h00, 8'h00, 0,   0, 0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0};
    vecs[1]  = '{0, 1, 1, 0, 8'hAA, 0, 0, 0, 8'h00, 8'h00, 0,   1, 0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0};
    vecs[2]  = '{0, 0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0,   0, 0, 0, 1, 0, 8'hAA, 0, 0, 8'h00, 0};
    vecs[3]  = '{0, 0, 0, 0, 8'h00, 1, 0, 0, 8'h00, 8'h00, 0,   0, 0, 0, 0, 0, 8'hAA, 1, 0, 8'hAA, 0};
    vecs[4]  = '{0, 0, 0, 0, 8'h00, 1, 0, 0, 8'h00, 8'h00, 0,   0, 1, 0, 0, 0, 8'hAA, 0, 0, 8'h00, 0};
    vecs[5]  = '{0, 0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0,   0, 0, 1, 0, 0, 8'h00, 0, 0, 8'h00, 0};
    vecs[6]  = '{0, 0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 8'hAA, 1,   0, 0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0};
    vecs[7]  = '{0, 0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0,   0, 0, 0, 0, 0, 8'h00, 0, 1, 8'hAA, 0};
    vecs[8]  = '{0, 0, 0, 0, 8'h00, 1, 1, 3, 8'h5C, 8'h33, 1,   0, 1, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0};
    vecs[9]  = '{0, 1, 0, 2, 8'h00, 0, 0, 0, 8'h00, 8'h33, 1,   0, 0, 0, 1, 3, 8'h5C, 0, 0, 8'h00, 0};
    vecs[10] = '{0, 1, 0, 2, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0,   0, 0, 0, 0, 3, 8'h5C, 0, 1, 8'h5C, 0};
    vecs[11] = '{0, 1, 0, 2, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0,   1, 0, 0, 0, 3, 8'h5C, 0, 0, 8'h00, 0};
    vecs[12] = '{0, 0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0,   0, 0, 1, 0, 2, 8'h00, 0, 0, 8'h00, 0};
    vecs[13] = '{0, 0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 8'h7E, 1,   0, 0, 0, 0, 2, 8'h00, 0, 0, 8'h00, 0};
    vecs[14] = '{0, 0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0,   0, 0, 0, 0, 2, 8'h00, 1, 0, 8'h7E, 0};

    idleInputs();
    rst = 1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i]);
      #1 checkOutput(vecs[i], i);
      @(negedge clk);
    end

    // Both requesters valid from reset: grants alternate starting with 0.
    doReset();
    req0_valid = 1; req0_write = 1; req0_addr = 1; req0_wdata = 8'h11;
    req1_valid = 1; req1_write = 1; req1_addr = 2; req1_wdata = 8'h22;
    grants = 0; rsps = 0; cyc = 0; exp_grant = 0; last_grant = 0;
    while (rsps < 4 && cyc < 60) begin
      #1;
      if (req0_ready || req1_ready) begin
        check("alt_grant_id", req1_ready, exp_grant);
        check("alt_grant_single", req0_ready & req1_ready, 1'b0);
        last_grant = req1_ready;
        exp_grant = ~exp_grant;
        grants++;
      end
      if (rsp0_valid || rsp1_valid) begin
        check("alt_rsp_single", rsp0_valid & rsp1_valid, 1'b0);
        check("alt_rsp_target", rsp1_valid, last_grant);
        check("alt_rsp_data", last_grant ? rsp1_data : rsp0_data, last_grant ? 8'h22 : 8'h11);
        rsps++;
      end
      @(negedge clk);
      cyc++;
    end
    check("alt_grant_count", grants, 4);
    check("alt_rsp_count", rsps, 4);

    // Lone req1 writes back to back: one accept every three cycles.
    doReset();
    req1_valid = 1; req1_write = 1; req1_addr = 1; req1_wdata = 8'h40;
    n = 0; cyc = 0;
    while (n < 3 && cyc < 40) begin
      #1;
      check("lone_req0_ready", req0_ready, 1'b0);
      if (req1_ready) begin
        times[n] = cyc;
        n++;
      end
      @(negedge clk);
      cyc++;
    end
    check("lone_accepts", n, 3);
    check("lone_spacing_1", times[1] - times[0], 3);
    check("lone_spacing_2", times[2] - times[1], 3);

    // Read with the box never answering: error response after TIMEOUT wait cycles.
    doReset();
    req0_valid = 1; req0_write = 0; req0_addr = 1;
    #1 check("to_accept", req0_ready, 1'b1);
    @(negedge clk);
    idleInputs();
    cyc = 1; found = 0;
    while (!found && cyc < 20) begin
      #1;
      if (rsp0_valid) found = 1;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
    check("to_seen", found, 1);
    check("to_latency", cyc, TIMEOUT + 2);
    check("to_data", rsp0_data, 8'h00);
    check("to_err", rsp0_err, 1'b1);
    check("to_rsp1_quiet", rsp1_valid, 1'b0);
    @(negedge clk);

    // Reset while waiting for read data: transaction dropped, rr back to 0.
    doReset();
    req1_valid = 1; req1_write = 0; req1_addr = 3;
    #1 check("rw_accept", req1_ready, 1'b1);
    @(negedge clk);
    idleInputs();
    @(negedge clk);
    rst = 1;
    #1 check("rw_ready_in_rst", {req0_ready, req1_ready}, 2'b00);
    @(negedge clk);
    rst = 0;
    #1;
    check("rw_ctrl_zero", {req0_ready, req1_ready, rsp0_valid, rsp0_err, rsp1_valid, rsp1_err,
                           box_read_enable, box_write_enable, box_address}, 10'h000);
    check("rw_data_zero", {rsp0_data, rsp1_data, box_write_data}, 24'h000000);
    for (int k = 0; k < 6; k++) begin
      box_read_active = 1; box_read_data = 8'h99;
      #1 check($sformatf("rw_quiet%0d", k),
               {rsp0_valid, rsp1_valid, box_read_enable, box_write_enable}, 4'h0);
      @(negedge clk);
    end
    idleInputs();
    req0_valid = 1; req0_write = 1; req1_valid = 1; req1_write = 1;
    #1;
    check("rw_next_req0", req0_ready, 1'b1);
    check("rw_next_req1", req1_ready, 1'b0);
    @(negedge clk);
    idleInputs();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
